// File: rtl/lsu_store_serializer_pkg.sv
// Shared lane geometry, state encoding and address helper for the
// vector store serializer.
package lsu_store_serializer_pkg;

    localparam int NUM_LANES  = 64;
    localparam int WORD_W     = 32;
    localparam int TAG_W      = 7;
    localparam int LANE_IDX_W = 6;
    localparam int DATA_W     = NUM_LANES * WORD_W;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Byte address of a lane: base + 4*idx, wrapping at 2^32.
    function automatic logic [31:0] lane_addr(input logic [31:0] base,
                                              input logic [LANE_IDX_W-1:0] idx);
        return base + {{(32-LANE_IDX_W-2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/lsu_lane_ffs.sv
// Find-first-set over the remaining-lane mask: lowest set bit wins.
module lsu_lane_ffs
    import lsu_store_serializer_pkg::*;
(
    input  logic [NUM_LANES-1:0]  vec,
    output logic [LANE_IDX_W-1:0] idx,
    output logic                  found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = LANE_IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsu_store_serializer.sv
// Serializes a masked 64-lane vector store into single 32-bit memory
// writes, lowest active lane first, one outstanding word at a time.
module lsu_store_serializer
    import lsu_store_serializer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_start,
    input  logic [DATA_W-1:0]     in_wr_data,
    input  logic [NUM_LANES-1:0]  in_exec_mask,
    input  logic [31:0]           in_base_addr,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic                  in_mem_ack,
    output logic                  out_mem_wr_en,
    output logic [31:0]           out_mem_addr,
    output logic [WORD_W-1:0]     out_mem_wr_data,
    output logic [TAG_W-1:0]      out_mem_tag,
    output logic                  out_busy,
    output logic                  out_done,
    output logic [TAG_W-1:0]      out_tag
);

    state_t                state_q;
    logic [DATA_W-1:0]     data_q;
    logic [NUM_LANES-1:0]  rem_q;
    logic [31:0]           base_q;
    logic [TAG_W-1:0]      tag_q;

    logic [LANE_IDX_W-1:0] lane_idx;
    logic                  lane_found;
    logic [NUM_LANES-1:0]  rem_next;
    logic                  issue;
    logic                  done;

    lsu_lane_ffs u_ffs (
        .vec   (rem_q),
        .idx   (lane_idx),
        .found (lane_found)
    );

    assign issue    = (state_q == ST_ISSUE);
    assign done     = (state_q == ST_DONE);
    assign rem_next = rem_q & ~(NUM_LANES'(1) << lane_idx);

    // Outputs are pure decodes of reset-cleared state, so reset zeroes them at once.
    assign out_mem_wr_en   = issue & lane_found;
    assign out_mem_addr    = out_mem_wr_en ? lane_addr(base_q, lane_idx) : '0;
    assign out_mem_wr_data = out_mem_wr_en ? data_q[{lane_idx, 5'b00000} +: WORD_W] : '0;
    assign out_mem_tag     = out_mem_wr_en ? tag_q : '0;
    assign out_busy        = issue | done;
    assign out_done        = done;
    assign out_tag         = done ? tag_q : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            base_q  <= '0;
            tag_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_start) begin
                        data_q  <= in_wr_data;
                        rem_q   <= in_exec_mask;
                        base_q  <= in_base_addr;
                        tag_q   <= in_tag;
                        state_q <= (in_exec_mask != '0) ? ST_ISSUE : ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    if (out_mem_wr_en && in_mem_ack) begin
                        rem_q <= rem_next;
                        if (rem_next == '0) state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_store_serializer.md
LSU_STORE_SERIALIZER -- requirements
Module: lsu_store_serializer

Interface
REQ-001 clk  input  1  clock; all state updates on the rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; asserted at 0.
REQ-003 in_start  input  1  one-cycle request to begin a vector store; sampled only in IDLE.
REQ-004 in_wr_data  input  2048  store data; lane i occupies bits [32i+31:32i], i = 0..63.
REQ-005 in_exec_mask  input  64  bit i = 1 means lane i is written.
REQ-006 in_base_addr  input  32  byte address of lane 0; lane i address = base + 4*i, modulo 2^32.
REQ-007 in_tag  input  7  request tag.
REQ-008 in_mem_ack  input  1  memory accepts the currently presented word.
REQ-009 out_mem_wr_en  output  1  word valid toward memory.
REQ-010 out_mem_addr  output  32  address of the presented word.
REQ-011 out_mem_wr_data  output  32  data of the presented word.
REQ-012 out_mem_tag  output  7  captured tag, presented with every word.
REQ-013 out_busy  output  1  high in ISSUE and DONE.
REQ-014 out_done  output  1  one-cycle completion pulse.
REQ-015 out_tag  output  7  captured tag; valid when out_done = 1.

Function
REQ-016 States SHALL be IDLE, ISSUE and DONE.
REQ-017 In IDLE, in_start = 1 SHALL capture in_wr_data, in_exec_mask, in_base_addr and in_tag into internal registers.
- If the captured mask is non-zero, the next state SHALL be ISSUE.
- If the captured mask is zero, the next state SHALL be DONE.
REQ-018 in_start outside IDLE SHALL be ignored, with no change to the captured registers.
REQ-019 In ISSUE, out_mem_wr_en SHALL be 1 and SHALL present the lowest-numbered lane whose remaining-mask bit is set.
- Lanes are issued in ascending order.
- Masked-off lanes are skipped at zero cycle cost.
REQ-020 Address, data and tag SHALL remain stable while out_mem_wr_en = 1 and in_mem_ack = 0.
REQ-021 When out_mem_wr_en = 1 and in_mem_ack = 1, the serializer SHALL clear that lane's remaining-mask bit.
- If no bits remain, the next state SHALL be DONE.
- Otherwise it SHALL present the next active lane in the following cycle.
REQ-022 At most one word SHALL be outstanding at any time; throughput is one word per cycle when in_mem_ack is held at 1.
REQ-023 in_mem_ack while out_mem_wr_en = 0 SHALL be ignored.
REQ-024 Latency: in_start in cycle T SHALL give the first out_mem_wr_en in cycle T+1; the final ack in cycle A SHALL give out_done = 1 in cycle A+1.
REQ-025 DONE SHALL last exactly one cycle with out_done = 1 and out_tag valid, then return to IDLE; in_start in DONE SHALL be ignored.
REQ-026 Outside ISSUE, out_mem_wr_en SHALL be 0.
- out_mem_addr, out_mem_wr_data and out_mem_tag SHALL be 0 when out_mem_wr_en = 0.

Reset
REQ-027 While rst = 0, the following SHALL be forced immediately, independent of clk:
- state = IDLE;
- all captured registers and the remaining mask = 0;
- every output = 0.
REQ-028 Reset asserted mid-ISSUE SHALL abandon the store: no further words, and no out_done.
REQ-029 After rst returns to 1, the first in_start SHALL be accepted on the next rising edge.

Structure
REQ-030 A shared package SHALL hold:
- NUM_LANES = 64, WORD_W = 32, TAG_W = 7, LANE_IDX_W = 6;
- the state enumeration.
REQ-031 Lane selection SHALL be a sub-module, lsu_lane_ffs: a 64-bit find-first-set encoder giving a 6-bit index and a found flag.
REQ-032 No other sub-modules; all storage SHALL use flip-flops with asynchronous active-low reset.

Verification
REQ-033 Full mask, ack held at 1, base 0x1000, lane i data = i:
- 64 consecutive words, addresses 0x1000..0x10FC, data 0..63;
- out_done in cycle T+65.
REQ-034 Mask 0x8000_0000_0000_0001, ack held at 1:
- lane 0 at base, then lane 63 at base+0xFC in consecutive cycles;
- out_done one cycle after the second ack.
REQ-035 Mask 0x0000_0000_0000_0000: no out_mem_wr_en, and out_done with out_tag = in_tag in cycle T+1.
REQ-036 Mask 0x5, ack withheld for 3 cycles:
- lane 0 address, data and tag stable for all 4 cycles;
- lane 2 presented the cycle after the ack.
REQ-037 Base 0xFFFF_FFF8, mask 0x7: addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap-around).
REQ-038 Second in_start mid-ISSUE, then reset after 2 words of a full mask:
- the second start is ignored;
- the reset abandons the store: no further words, and no out_done;
- out_busy = 0 and all outputs = 0 immediately.
